// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
// Used by mips_multicycle_ctrl and mips_alu_decoder.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_ADDIEX,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP,
      S_BNE
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation and flags whether
// the funct is one the datapath supports. Purely combinational.
import mips_ctrl_pkg::*;

module mips_alu_decoder (
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_valid
);

   // funct lookup; unsupported codes fall back to add and are flagged invalid
   always_comb begin
      alu_ctrl    = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control sequencer with memory-ready handshake and
// retired-instruction counter.
// Optional build macro MC_BNE_EN adds a BNE state for opcode 000101;
// without it that opcode is treated as illegal.
//
// state  | meaning
// RST    | post-reset idle cycle, all outputs low
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | compute branch target, dispatch on opcode
// MEMADR | compute load/store address
// MEMRD  | data memory read, waits on mem_ready
// MEMWB  | write loaded data to rt
// MEMWR  | data memory write, waits on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// ADDIEX | A + sign-extended immediate
// ADDIWB | write addi result to rt
// BRANCH | beq compare and conditional PC load
// JUMP   | load jump target into PC
// BNE    | bne compare and conditional PC load (MC_BNE_EN only)
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [2:0]          alu_ctrl,
   output logic [1:0]          pc_src,
   output logic                illegal_op,
   output logic                instr_done,
   output logic [RETIRE_W-1:0] retired_count
);

   localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_nxt;
   logic [2:0] fn_alu_ctrl;
   logic       fn_valid;

   mips_alu_decoder u_alu_dec (
      .funct       (funct),
      .alu_ctrl    (fn_alu_ctrl),
      .funct_valid (fn_valid)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_RST;
      else       state <= state_nxt;
   end

   // Retired-instruction counter, wraps naturally past all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           retired_count <= '0;
      else if (instr_done) retired_count <= retired_count + RETIRE_ONE;
   end

   // Next-state and output decode
   always_comb begin
      state_nxt  = state;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_ctrl   = ALU_AND;
      pc_src     = PC_ALU;
      illegal_op = 1'b0;
      instr_done = 1'b0;

      case (state)
         S_RST: state_nxt = S_FETCH;

         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_ctrl  = ALU_ADD;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) state_nxt = S_DECODE;
         end

         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            alu_ctrl  = ALU_ADD;
            case (opcode)
               OP_R: begin
                  if (fn_valid) begin
                     state_nxt = S_EXEC;
                  end else begin
                     illegal_op = 1'b1;
                     state_nxt  = S_FETCH;
                  end
               end
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
`ifdef MC_BNE_EN
               OP_BNE:       state_nxt = S_BNE;
`else
               OP_BNE: begin
                  illegal_op = 1'b1;
                  state_nxt  = S_FETCH;
               end
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_nxt  = S_FETCH;
               end
            endcase
         end

         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = ALU_ADD;
            state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end

         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_nxt = S_MEMWB;
         end

         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_nxt = S_FETCH;
         end

         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_ctrl  = fn_alu_ctrl;
            state_nxt = S_ALUWB;
         end

         S_ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = ALU_ADD;
            state_nxt = S_ADDIWB;
         end

         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_B;
            alu_ctrl   = ALU_SUB;
            pc_src     = PC_ALUOUT;
            pc_en      = zero;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_JUMP: begin
            pc_src     = PC_JUMP;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end

`ifdef MC_BNE_EN
         S_BNE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_B;
            alu_ctrl   = ALU_SUB;
            pc_src     = PC_ALUOUT;
            pc_en      = ~zero;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
`endif

         default: state_nxt = S_RST;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. The driver applies inputs each
// cycle and queues the expected outputs; a monitor on the falling edge pops
// and compares. Honours MC_BNE_EN for the opcode 000101 case.
module tb_mips_multicycle_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_en, iord, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctrl;
   logic [1:0]  pc_src;
   logic        illegal_op, instr_done;
   logic [31:0] retired_count;

   mips_multicycle_ctrl #(.RETIRE_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_en         (pc_en),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_ctrl      (alu_ctrl),
      .pc_src        (pc_src),
      .illegal_op    (illegal_op),
      .instr_done    (instr_done),
      .retired_count (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [17:0] outs;
      logic [31:0] cnt;
   } item_t;

   item_t       q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cnt  = 0;
   logic        driver_done = 1'b0;

   // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
   //  alu_src_a,alu_src_b,alu_ctrl,pc_src,illegal_op,instr_done}
   function automatic logic [17:0] v(input logic pe, io, mr, mw, irw, rd, m2r, rw, a,
                                     input logic [1:0] b, input logic [2:0] c,
                                     input logic [1:0] ps, input logic ill, done);
      return {pe, io, mr, mw, irw, rd, m2r, rw, a, b, c, ps, ill, done};
   endfunction

   function automatic logic [17:0] actual_outs();
      return {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_op, instr_done};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic push(input string nm, input logic [17:0] e);
      item_t it;
      it.name = nm;
      it.outs = e;
      it.cnt  = exp_cnt;
      q.push_back(it);
      if (e[0]) exp_cnt++;
   endtask

   task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [17:0] e);
      @(posedge clk);
      #1;
      opcode    = op;
      funct     = fn;
      zero      = z;
      mem_ready = rdy;
      push(nm, e);
   endtask

   // Monitor: compare every queued expectation on the falling edge
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            it = q.pop_front();
            n_checks++;
            if (actual_outs() !== it.outs) begin
               n_fail++;
               $display("FAIL %s outs: got %b want %b", it.name, actual_outs(), it.outs);
            end
            n_checks++;
            if (retired_count !== it.cnt) begin
               n_fail++;
               $display("FAIL %s count: got %0d want %0d", it.name, retired_count, it.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "timeout");
   end

   logic [17:0] E_RST, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWB;
   logic [17:0] E_ALUWB, E_ADDIEX, E_ADDIWB, E_JUMP;
   logic [5:0]  fn_tab [5];
   logic [2:0]  ctrl_tab [5];

   function automatic logic [17:0] e_fetch(input logic rdy);
      return v(rdy, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0);
   endfunction
   function automatic logic [17:0] e_memwr(input logic rdy);
      return v(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, rdy);
   endfunction
   function automatic logic [17:0] e_exec(input logic [2:0] c);
      return v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, c, 2'b00, 0, 0);
   endfunction
   function automatic logic [17:0] e_branch(input logic pe);
      return v(pe, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 1);
   endfunction

   // Directed stimulus
   initial begin
      E_RST     = '0;
      E_DEC     = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0);
      E_DEC_ILL = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1, 0);
      E_MEMADR  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
      E_MEMRD   = v(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      E_MEMWB   = v(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1);
      E_ALUWB   = v(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1);
      E_ADDIEX  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
      E_ADDIWB  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1);
      E_JUMP    = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 1);
      fn_tab    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ctrl_tab  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      push("rst_held", E_RST);
      @(posedge clk); #1;
      reset = 1'b0;
      push("rst_release", E_RST);

      // addi
      step("addi_fetch",  6'b001000, 6'b000000, 0, 1, e_fetch(1));
      step("addi_decode", 6'b001000, 6'b000000, 0, 1, E_DEC);
      step("addi_ex",     6'b001000, 6'b000000, 0, 1, E_ADDIEX);
      step("addi_wb",     6'b001000, 6'b000000, 0, 1, E_ADDIWB);

      // R-type, every supported funct
      for (int i = 0; i < 5; i++) begin
         step("r_fetch",  6'b000000, fn_tab[i], 0, 1, e_fetch(1));
         step("r_decode", 6'b000000, fn_tab[i], 0, 1, E_DEC);
         step("r_exec",   6'b000000, fn_tab[i], 0, 1, e_exec(ctrl_tab[i]));
         step("r_wb",     6'b000000, fn_tab[i], 0, 1, E_ALUWB);
      end

      // lw with 3 wait cycles in MEMRD; mem_ready low in DECODE/MEMADR is ignored
      step("lw_fetch",  6'b100011, 6'b000000, 0, 1, e_fetch(1));
      step("lw_decode", 6'b100011, 6'b000000, 0, 0, E_DEC);
      step("lw_memadr", 6'b100011, 6'b000000, 0, 0, E_MEMADR);
      step("lw_wait1",  6'b100011, 6'b000000, 0, 0, E_MEMRD);
      step("lw_wait2",  6'b100011, 6'b000000, 0, 0, E_MEMRD);
      step("lw_wait3",  6'b100011, 6'b000000, 0, 0, E_MEMRD);
      step("lw_memrd",  6'b100011, 6'b000000, 0, 1, E_MEMRD);
      step("lw_memwb",  6'b100011, 6'b000000, 0, 1, E_MEMWB);

      // sw with one fetch wait cycle
      step("sw_fetch_wait", 6'b101011, 6'b000000, 0, 0, e_fetch(0));
      step("sw_fetch",      6'b101011, 6'b000000, 0, 1, e_fetch(1));
      step("sw_decode",     6'b101011, 6'b000000, 0, 1, E_DEC);
      step("sw_memadr",     6'b101011, 6'b000000, 0, 1, E_MEMADR);
      step("sw_memwr",      6'b101011, 6'b000000, 0, 1, e_memwr(1));

      // beq taken and not taken
      step("beq1_fetch",  6'b000100, 6'b000000, 1, 1, e_fetch(1));
      step("beq1_decode", 6'b000100, 6'b000000, 1, 1, E_DEC);
      step("beq1_branch", 6'b000100, 6'b000000, 1, 1, e_branch(1));
      step("beq0_fetch",  6'b000100, 6'b000000, 0, 1, e_fetch(1));
      step("beq0_decode", 6'b000100, 6'b000000, 0, 1, E_DEC);
      step("beq0_branch", 6'b000100, 6'b000000, 0, 1, e_branch(0));

      // jump
      step("j_fetch",  6'b000010, 6'b000000, 0, 1, e_fetch(1));
      step("j_decode", 6'b000010, 6'b000000, 0, 1, E_DEC);
      step("j_jump",   6'b000010, 6'b000000, 0, 1, E_JUMP);

      // illegal opcode and illegal funct
      step("ill_op_fetch",  6'b111111, 6'b000000, 0, 1, e_fetch(1));
      step("ill_op_decode", 6'b111111, 6'b000000, 0, 1, E_DEC_ILL);
      step("ill_fn_fetch",  6'b000000, 6'b000000, 0, 1, e_fetch(1));
      step("ill_fn_decode", 6'b000000, 6'b000000, 0, 1, E_DEC_ILL);

      // opcode 000101
`ifdef MC_BNE_EN
      step("bne0_fetch",  6'b000101, 6'b000000, 0, 1, e_fetch(1));
      step("bne0_decode", 6'b000101, 6'b000000, 0, 1, E_DEC);
      step("bne0_bne",    6'b000101, 6'b000000, 0, 1, e_branch(1));
      step("bne1_fetch",  6'b000101, 6'b000000, 1, 1, e_fetch(1));
      step("bne1_decode", 6'b000101, 6'b000000, 1, 1, E_DEC);
      step("bne1_bne",    6'b000101, 6'b000000, 1, 1, e_branch(0));
`else
      step("bne_fetch",  6'b000101, 6'b000000, 0, 1, e_fetch(1));
      step("bne_decode", 6'b000101, 6'b000000, 0, 1, E_DEC_ILL);
`endif

      // sw stalled in MEMWR, then reset mid-wait
      step("swr_fetch",  6'b101011, 6'b000000, 0, 1, e_fetch(1));
      step("swr_decode", 6'b101011, 6'b000000, 0, 1, E_DEC);
      step("swr_memadr", 6'b101011, 6'b000000, 0, 1, E_MEMADR);
      step("swr_wait",   6'b101011, 6'b000000, 0, 0, e_memwr(0));
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_async_mem_write", {31'd0, mem_write}, 32'd0);
      chk("rst_async_mem_read",  {31'd0, mem_read}, 32'd0);
      chk("rst_async_count",     retired_count, 32'd0);
      exp_cnt = 0;
      step("rst_mid_hold", 6'b101011, 6'b000000, 0, 0, E_RST);
      @(posedge clk); #1;
      reset = 1'b0;
      push("rst_mid_release", E_RST);
      step("post_j_fetch",  6'b000010, 6'b000000, 0, 1, e_fetch(1));
      step("post_j_decode", 6'b000010, 6'b000000, 0, 1, E_DEC);
      step("post_j_jump",   6'b000010, 6'b000000, 0, 1, E_JUMP);
      step("post_j_next",   6'b000000, 6'b000000, 0, 0, e_fetch(0));

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      driver_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
